// File: rtl/multicycle_ctrl_pkg.sv
// mc_pkg: shared opcodes, state encodings, control codes and control-vector type for the multicycle controller
package mc_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    R_EX     = 4'd2,
    R_WB     = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WB   = 4'd6,
    MEM_WR   = 4'd7,
    BEQ      = 4'd8,
    JUMP     = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11
  } state_e;
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       illegal;
  } ctrl_t;
  function automatic logic legal_op(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
           op == OP_BEQ || op == OP_J || op == OP_ADDI;
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: IR opcode / memory handshake in, datapath control and retire count out
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pcwrite;
  logic             pcwritecond;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             memtoreg;
  logic             regdst;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic [1:0]       pcsource;
  logic             illegal;
  logic [CNT_W-1:0] retired;
  modport master (
    input  opcode, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, aluop, pcsource, illegal, retired
  );
  modport slave (
    output opcode, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, aluop, pcsource, illegal, retired
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode: combinational state -> control-vector table (Moore, plus mem_ready strobes)
module multicycle_ctrl_decode
  import mc_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memread  = 1'b1;
        ctrl.alusrcb  = SRCB_FOUR;
        ctrl.irwrite  = mem_ready;
        ctrl.pcwrite  = mem_ready;
      end
      DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.illegal = !legal_op(opcode);
      end
      R_EX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALU_FUNCT;
      end
      R_WB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      MEM_ADDR, ADDI_EX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      MEM_RD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEM_WB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      MEM_WR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      BEQ: begin
        ctrl.alusrca     = 1'b1;
        ctrl.aluop       = ALU_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PC_ALUOUT;
      end
      JUMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PC_JUMP;
      end
      ADDI_WB: ctrl.regwrite = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS control FSM with memory-ready stalls and retired-instruction counter
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);
  state_e           state, next;
  ctrl_t            ctrl, out;
  logic [CNT_W-1:0] retired;
  logic             retire;
  multicycle_ctrl_decode u_decode (
    .state    (state),
    .opcode   (bus.opcode),
    .mem_ready(bus.mem_ready),
    .ctrl     (ctrl)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FETCH;
    else     state <= next;
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:    next = bus.mem_ready ? DECODE : FETCH;
      DECODE:   next = bus.opcode == OP_RTYPE ? R_EX :
                       (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEM_ADDR :
                       bus.opcode == OP_BEQ ? BEQ :
                       bus.opcode == OP_J ? JUMP :
                       bus.opcode == OP_ADDI ? ADDI_EX : FETCH;
      R_EX:     next = R_WB;
      MEM_ADDR: next = bus.opcode == OP_SW ? MEM_WR : MEM_RD;
      MEM_RD:   next = bus.mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:   next = bus.mem_ready ? FETCH : MEM_WR;
      ADDI_EX:  next = ADDI_WB;
      default:  next = FETCH;
    endcase
  end
  // an instruction retires on the edge leaving its final state
  assign retire = state == R_WB || state == MEM_WB || state == BEQ || state == JUMP ||
                  state == ADDI_WB || (state == MEM_WR && bus.mem_ready);
  always_ff @(posedge clk or posedge rst)
    if (rst)         retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  // reset forces every control low, even the memread FETCH would otherwise drive
  assign out             = rst ? '0 : ctrl;
  assign bus.pcwrite     = out.pcwrite;
  assign bus.pcwritecond = out.pcwritecond;
  assign bus.iord        = out.iord;
  assign bus.memread     = out.memread;
  assign bus.memwrite    = out.memwrite;
  assign bus.irwrite     = out.irwrite;
  assign bus.memtoreg    = out.memtoreg;
  assign bus.regdst      = out.regdst;
  assign bus.regwrite    = out.regwrite;
  assign bus.alusrca     = out.alusrca;
  assign bus.alusrcb     = out.alusrcb;
  assign bus.aluop       = out.aluop;
  assign bus.pcsource    = out.pcsource;
  assign bus.illegal     = out.illegal;
  assign bus.retired     = retired;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed checks of the control FSM; a 4-bit-counter copy shares stimulus for the wrap test
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  multicycle_ctrl_if #(.CNT_W(32)) a ();
  multicycle_ctrl_if #(.CNT_W(4))  b ();
  multicycle_ctrl #(.CNT_W(32)) dut   (.clk(clk), .rst(rst), .bus(a.master));
  multicycle_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(b.master));
  assign b.opcode    = a.opcode;
  assign b.mem_ready = a.mem_ready;
  always #5 clk = ~clk;
  wire [18:0] all_ctl = {a.pcwrite, a.pcwritecond, a.iord, a.memread, a.memwrite, a.irwrite,
                         a.memtoreg, a.regdst, a.regwrite, a.alusrca, a.alusrcb, a.aluop,
                         a.pcsource, a.illegal, b.illegal};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic step(input logic [5:0] op, input logic mr);
    @(negedge clk);
    a.opcode    = op;
    a.mem_ready = mr;
    #1;
  endtask
  initial begin
    a.opcode    = 6'd0;
    a.mem_ready = 1'b0;
    #1;
    chk("rst_ctl", 32'(all_ctl), 0);
    chk("rst_retired", a.retired, 0);
    @(negedge clk);
    rst = 1'b0;
    // R-type
    step(6'b000000, 1);
    chk("r_fetch_memread", a.memread, 1);
    chk("r_fetch_irwrite", a.irwrite, 1);
    chk("r_fetch_pcwrite", a.pcwrite, 1);
    chk("r_fetch_srcb", a.alusrcb, 1);
    chk("r_retired0", a.retired, 0);
    step(6'b000000, 1);
    chk("r_dec_srcb", a.alusrcb, 3);
    chk("r_dec_regwrite", a.regwrite, 0);
    step(6'b000000, 1);
    chk("r_ex_aluop", a.aluop, 2);
    chk("r_ex_srca", a.alusrca, 1);
    chk("r_ex_regwrite", a.regwrite, 0);
    step(6'b000000, 1);
    chk("r_wb_regwrite", a.regwrite, 1);
    chk("r_wb_regdst", a.regdst, 1);
    chk("r_wb_retired", a.retired, 0);
    // lw with 3 stall cycles in MEM_RD
    step(6'b100011, 1);
    chk("lw_fetch_memread", a.memread, 1);
    chk("r_retired1", a.retired, 1);
    step(6'b100011, 1);
    chk("lw_dec_srcb", a.alusrcb, 3);
    step(6'b100011, 1);
    chk("lw_addr_srcb", a.alusrcb, 2);
    chk("lw_addr_srca", a.alusrca, 1);
    for (int i = 0; i < 3; i++) begin
      step(6'b100011, 0);
      chk("lw_stall_memread", a.memread, 1);
      chk("lw_stall_iord", a.iord, 1);
    end
    step(6'b100011, 1);
    chk("lw_rd_memread", a.memread, 1);
    chk("lw_rd_iord", a.iord, 1);
    step(6'b100011, 1);
    chk("lw_wb_memtoreg", a.memtoreg, 1);
    chk("lw_wb_regwrite", a.regwrite, 1);
    chk("lw_wb_regdst", a.regdst, 0);
    chk("lw_wb_memread", a.memread, 0);
    step(6'b100011, 1);
    chk("lw_retired2", a.retired, 2);
    // reset in the middle of MEM_RD
    step(6'b100011, 1);
    step(6'b100011, 1);
    step(6'b100011, 0);
    chk("rst_pre_memread", a.memread, 1);
    chk("rst_pre_iord", a.iord, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ctl", 32'(all_ctl), 0);
    chk("rst_mid_retired", a.retired, 0);
    @(negedge clk);
    #1;
    chk("rst_hold_ctl", 32'(all_ctl), 0);
    rst = 1'b0;
    // sw, beq, j back to back
    step(6'b101011, 1);
    chk("after_rst_memread", a.memread, 1);
    chk("after_rst_iord", a.iord, 0);
    step(6'b101011, 1);
    step(6'b101011, 1);
    chk("sw_addr_srcb", a.alusrcb, 2);
    chk("sw_addr_memwrite", a.memwrite, 0);
    step(6'b101011, 1);
    chk("sw_wr_memwrite", a.memwrite, 1);
    chk("sw_wr_iord", a.iord, 1);
    chk("sw_wr_memread", a.memread, 0);
    step(6'b000100, 1);
    chk("beq_fetch_memwrite", a.memwrite, 0);
    chk("sw_retired1", a.retired, 1);
    step(6'b000100, 1);
    chk("beq_dec_pcwc", a.pcwritecond, 0);
    step(6'b000100, 1);
    chk("beq_pcwc", a.pcwritecond, 1);
    chk("beq_pcsrc", a.pcsource, 1);
    chk("beq_aluop", a.aluop, 1);
    chk("beq_pcwrite", a.pcwrite, 0);
    step(6'b000010, 1);
    chk("j_fetch_pcwc", a.pcwritecond, 0);
    chk("beq_retired2", a.retired, 2);
    step(6'b000010, 1);
    chk("j_dec_pcwrite", a.pcwrite, 0);
    step(6'b000010, 1);
    chk("j_pcwrite", a.pcwrite, 1);
    chk("j_pcsrc", a.pcsource, 2);
    step(6'b111111, 1);
    chk("j_retired3", a.retired, 3);
    chk("ill_fetch_illegal", a.illegal, 0);
    // illegal opcode
    step(6'b111111, 1);
    chk("ill_dec_illegal", a.illegal, 1);
    chk("ill_dec_regwrite", a.regwrite, 0);
    chk("ill_dec_memwrite", a.memwrite, 0);
    step(6'b001000, 1);
    chk("ill_back_fetch", a.memread, 1);
    chk("ill_pulse_end", a.illegal, 0);
    chk("ill_retired", a.retired, 3);
    // addi
    step(6'b001000, 1);
    step(6'b001000, 1);
    chk("addi_ex_srcb", a.alusrcb, 2);
    chk("addi_ex_srca", a.alusrca, 1);
    step(6'b001000, 1);
    chk("addi_wb_regwrite", a.regwrite, 1);
    chk("addi_wb_memtoreg", a.memtoreg, 0);
    step(6'b000010, 1);
    chk("addi_retired4", a.retired, 4);
    // counter wrap: 17 jumps from reset
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) step(6'b000010, 1);
      step(6'b000010, 1);
      step(6'b000010, 1);
    end
    step(6'b000010, 1);
    chk("wrap_retired4", b.retired, 1);
    chk("wrap_retired32", a.retired, 17);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #100000;
    $fatal(1, "FAIL timeout: bench did not finish");
  end
endmodule
